// File: rtl/fifo_pkg.sv
// Shared types and defaults for the first-word-fall-through synchronous FIFO.
//   fifo_status_t : registered status flag bundle (full/empty/almost_*)
//   FIFO_DEF_*    : default parameter values used by fwft_sync_fifo
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  localparam int FIFO_DEF_WIDTH     = 512;
  localparam int FIFO_DEF_DEPTH     = 4;
  localparam int FIFO_DEF_AEMPTY_TH = 1;

endpackage

// File: rtl/fwft_fifo_ptr.sv
// Wrap-around pointer for a FIFO of DEPTH entries (any DEPTH >= 2).
//   clk, rst : clock, async active-high reset (pointer -> 0)
//   inc      : advance pointer at the rising edge
//   ptr      : current pointer value, 0..DEPTH-1
//   ptr_inc  : ptr+1 with wrap, available combinationally for lookahead
module fwft_fifo_ptr #(
  parameter int DEPTH = 4,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [PW-1:0] ptr,
  output logic [PW-1:0] ptr_inc
);

  // Explicit wrap compare so non-power-of-two depths never visit DEPTH..2^PW-1.
  assign ptr_inc = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      ptr <= '0;
    else if (inc) ptr <= ptr_inc;
  end

endmodule

// File: rtl/fwft_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// The head entry is held in a dedicated output register so dout is valid
// whenever empty=0 without a prefetch read.
//   clk, rst            : clock, async active-high reset
//   wr_en, din          : push request and data (dropped while full)
//   rd_en               : pop/acknowledge of dout (ignored while empty)
//   err_clr             : clears sticky overflow/underflow
//   dout                : head entry
//   full, empty,
//   almost_full,
//   almost_empty        : registered status, derived from next count
//   count               : occupancy 0..DEPTH
//   overflow, underflow : sticky error flags
// Optional feature: define FWFT_FIFO_ERR_EN to build the sticky error flags;
// otherwise they are tied low and err_clr is ignored.
module fwft_sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_DEF_WIDTH,
  parameter int DEPTH     = FIFO_DEF_DEPTH,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = FIFO_DEF_AEMPTY_TH,
  parameter int CNT_W     = $clog2(DEPTH + 1),
  parameter int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  input  logic             err_clr,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_ptr_inc;
  logic [PW-1:0]    unused_wr_ptr_inc;
  logic             push, pop;
  logic [CNT_W-1:0] count_nxt;
  logic [WIDTH-1:0] dout_nxt;
  fifo_status_t     stat, stat_nxt;

  // Full blocks the write even if a pop happens the same cycle.
  assign push = wr_en & ~stat.full;
  assign pop  = rd_en & ~stat.empty;

  fwft_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk(clk), .rst(rst), .inc(push), .ptr(wr_ptr), .ptr_inc(unused_wr_ptr_inc)
  );

  fwft_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk(clk), .rst(rst), .inc(pop), .ptr(rd_ptr), .ptr_inc(rd_ptr_inc)
  );

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

  // Next head: after a pop the new head is the next stored entry, unless the
  // popped entry was the last one, in which case it must be the incoming din.
  always_comb begin
    dout_nxt = dout;
    if (pop) begin
      if (count > CNT_W'(1)) dout_nxt = mem[rd_ptr_inc];
      else if (push)         dout_nxt = din;
    end else if (stat.empty && push) begin
      dout_nxt = din;
    end
  end

  always_comb begin
    stat_nxt.full         = (count_nxt == CNT_W'(DEPTH));
    stat_nxt.empty        = (count_nxt == '0);
    stat_nxt.almost_full  = (count_nxt >= CNT_W'(AFULL_TH));
    stat_nxt.almost_empty = (count_nxt <= CNT_W'(AEMPTY_TH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      dout  <= '0;
      stat  <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
    end else begin
      count <= count_nxt;
      dout  <= dout_nxt;
      stat  <= stat_nxt;
    end
  end

  assign full         = stat.full;
  assign empty        = stat.empty;
  assign almost_full  = stat.almost_full;
  assign almost_empty = stat.almost_empty;

`ifdef FWFT_FIFO_ERR_EN
  // Sticky flags; a clear in the same cycle as a new error wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (err_clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && stat.full)  overflow  <= 1'b1;
      if (rd_en && stat.empty) underflow <= 1'b1;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fwft_sync_fifo.sv
// Directed bench for fwft_sync_fifo (WIDTH=8, DEPTH=5). Expected error flags
// follow FWFT_FIFO_ERR_EN so the bench fits either build.
module tb_fwft_sync_fifo;

  localparam int W = 8;
  localparam int D = 5;
`ifdef FWFT_FIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, wr_en, rd_en, err_clr;
  logic [W-1:0] din, dout;
  logic         full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0]   count;

  int n_chk  = 0;
  int n_fail = 0;

  fwft_sync_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .err_clr(err_clr), .dout(dout), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [W-1:0] d, input logic r);
    wr_en = w; din = d; rd_en = r;
  endtask

  initial begin
    rst = 1'b1; err_clr = 1'b0;
    drive(1'b0, '0, 1'b0);
    #2;
    check("rst_empty",  empty, 1);
    check("rst_count",  count, 0);
    check("rst_full",   full, 0);
    check("rst_afull",  almost_full, 0);
    check("rst_aempty", almost_empty, 1);
    check("rst_dout",   dout, 0);
    check("rst_ovf",    overflow, 0);
    check("rst_unf",    underflow, 0);
    #5 rst = 1'b0;
    step();

    // single write falls through with no read
    drive(1'b1, 8'hA5, 1'b0); step(); drive(1'b0, '0, 1'b0);
    check("fwft_empty", empty, 0);
    check("fwft_dout",  dout, 8'hA5);
    check("fwft_count", count, 1);
    check("fwft_aempty", almost_empty, 1);
    drive(1'b0, '0, 1'b1); step(); drive(1'b0, '0, 1'b0);
    check("pop1_empty", empty, 1);
    check("pop1_count", count, 0);

    // fill with 1..5 (pointers start at 1 here, so the 5th write wraps)
    for (int i = 1; i <= D; i++) begin
      drive(1'b1, W'(i), 1'b0); step();
      check("fill_count", count, i);
      check("fill_dout",  dout, 1);
      check("fill_full",  full, (i == D) ? 1 : 0);
      check("fill_afull", almost_full, (i >= D - 1) ? 1 : 0);
    end
    drive(1'b1, 8'd6, 1'b0); step(); drive(1'b0, '0, 1'b0);
    check("drop_count", count, 5);
    check("drop_full",  full, 1);
    check("drop_ovf",   overflow, ERR);
    check("drop_dout",  dout, 1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("ovf_clr", overflow, 0);

    // write+read while full: pop taken, write dropped
    drive(1'b1, 8'd7, 1'b1); step(); drive(1'b0, '0, 1'b0);
    check("fullrw_count", count, 4);
    check("fullrw_dout",  dout, 2);
    check("fullrw_full",  full, 0);
    check("fullrw_ovf",   overflow, ERR);
    err_clr = 1'b1; step(); err_clr = 1'b0;

    // drain remaining 2..5 in order (7 must not appear)
    for (int i = 2; i <= D; i++) begin
      check("drain_dout", dout, i);
      drive(1'b0, '0, 1'b1); step(); drive(1'b0, '0, 1'b0);
    end
    check("drain_empty", empty, 1);
    check("drain_count", count, 0);

    // read on empty ignored, flag sticky until cleared
    drive(1'b0, '0, 1'b1); step(); drive(1'b0, '0, 1'b0);
    check("unf_set",   underflow, ERR);
    check("unf_count", count, 0);
    step();
    check("unf_sticky", underflow, ERR);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("unf_clr", underflow, 0);

    // read+write on empty: write accepted
    drive(1'b1, 8'h33, 1'b1); step(); drive(1'b0, '0, 1'b0);
    check("erw_count", count, 1);
    check("erw_dout",  dout, 8'h33);
    check("erw_unf",   underflow, ERR);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    drive(1'b0, '0, 1'b1); step(); drive(1'b0, '0, 1'b0);

    // steady push/pop at count=2 across many wraps
    drive(1'b1, 8'h10, 1'b0); step();
    drive(1'b1, 8'h11, 1'b0); step();
    for (int i = 0; i < 20; i++) begin
      check("ss_dout", dout, 8'h10 + i);
      drive(1'b1, W'(8'h12 + i), 1'b1); step();
      check("ss_count", count, 2);
    end
    drive(1'b0, '0, 1'b0);
    check("ss_tail", dout, 8'h10 + 20);

    // async reset with count=3, observed before the next edge
    drive(1'b1, 8'h55, 1'b0); step(); drive(1'b0, '0, 1'b0);
    check("pre_rst_count", count, 3);
    #2 rst = 1'b1;
    #1;
    check("arst_empty", empty, 1);
    check("arst_count", count, 0);
    check("arst_full",  full, 0);
    #2 rst = 1'b0;
    step();
    check("post_rst_empty", empty, 1);
    drive(1'b1, 8'h77, 1'b0); step(); drive(1'b0, '0, 1'b0);
    check("post_rst_dout",  dout, 8'h77);
    check("post_rst_count", count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
